// File: rtl/apb_master_arbiter_pkg.sv
// apb_master_pkg: APB master FSM encoding and default widths shared by apb_master_arbiter.
package apb_master_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
   localparam int APB_ADDR_WIDTH     = 8;
   localparam int APB_DATA_WIDTH     = 32;
   localparam int APB_NUM_REQ        = 2;
   localparam int APB_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at i_ptr; the pointer register lives in the parent.
module rr_arbiter
   import apb_master_pkg::*;
#(
   parameter int NUM_REQ = APB_NUM_REQ,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IW-1:0]      o_idx
);
   // Scan from farthest to nearest so the requester closest to the pointer wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         logic [IW-1:0] w_j;
         w_j = IW'((int'(i_ptr) + k) % NUM_REQ);
         if (i_req[w_j]) begin
            o_grant      = '0;
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
         end
      end
   end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin shares one APB bus between NUM_REQ requesters.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_arbiter
   import apb_master_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int NUM_REQ        = APB_NUM_REQ,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
   input  logic                          PCLK,
   input  logic                          PRESETn,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic                          PSEL,
   output logic                          PENABLE,
   output logic                          PWRITE,
   output logic [ADDR_WIDTH-1:0]         PADDR,
   output logic [DATA_WIDTH-1:0]         PWDATA,
   input  logic [DATA_WIDTH-1:0]         PRDATA,
   input  logic                          PREADY,
   input  logic                          PSLVERR
);
   localparam int IW = $clog2(NUM_REQ);

   apb_state_e             r_state;
   logic [IW-1:0]          r_ptr, r_win, w_idx;
   logic [NUM_REQ-1:0]     w_grant, r_rsp_valid;
   logic                   r_psel, r_penable, r_pwrite, r_rsp_err, w_tmo, w_done;
   logic [ADDR_WIDTH-1:0]  r_paddr;
   logic [DATA_WIDTH-1:0]  r_pwdata, r_rsp_rdata;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   assign req_ready = (PRESETn && r_state == IDLE) ? w_grant : '0;
   assign w_done    = (r_state == ACCESS) && (PREADY || w_tmo);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   // Abort on the TIMEOUT_CYCLES-th consecutive stalled ACCESS cycle.
   assign w_tmo = !PREADY && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge PCLK) begin
      if (!PRESETn || r_state == SETUP) r_cnt <= '0;
      else if (r_state == ACCESS && !PREADY) r_cnt <= r_cnt + 1'b1;
   end
`else
   assign w_tmo = TIMEOUT_CYCLES < 0;
`endif

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_win       <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            IDLE: if (|req_valid) begin
               r_win    <= w_idx;
               r_ptr    <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
               r_pwrite <= req_write[w_idx];
               r_paddr  <= req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
               r_pwdata <= req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
               r_psel   <= 1'b1;
               r_state  <= SETUP;
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: if (w_done) begin
               r_rsp_valid[r_win] <= 1'b1;
               r_rsp_rdata        <= (r_pwrite || w_tmo) ? '0 : PRDATA;
               r_rsp_err          <= PSLVERR || w_tmo;
               r_psel             <= 1'b0;
               r_penable          <= 1'b0;
               r_state            <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized bench with a register-file slave and a round-robin/memory reference model.
module tb_apb_master_arbiter;
   logic        PCLK = 1'b0, PRESETn;
   logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [31:0] rsp_rdata, PWDATA, PRDATA;
   logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [7:0]  PADDR;
   logic [31:0] smem [256];
   logic [31:0] ref_mem [256];
   int          ptr, n_chk, n_pass;
   int          o_g, o_lat, o_psel, o_pen;
   logic [1:0]  o_rv, o_rvn;
   logic [31:0] o_rd, o_pw;
   logic [7:0]  o_pa;
   logic        o_er, o_pwr, o_stable, o_extra;

   apb_master_arbiter dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   assign PRDATA = smem[PADDR];
   always @(posedge PCLK)
      if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) smem[PADDR] <= PWDATA;

   function automatic int pick(input logic [1:0] m);
      for (int k = 0; k < 2; k++) begin
         int idx;
         idx = (ptr + k) % 2;
         if (m[idx[0]]) return idx;
      end
      return -1;
   endfunction

   task automatic cyc();
      @(posedge PCLK);
      #2;
   endtask

   task automatic issue(input logic [1:0] mask, input logic [1:0] w, input logic [15:0] a,
                        input logic [63:0] d, input int waits, input logic serr, input logic [1:0] hold);
      int acc;
      req_valid = mask; req_write = w; req_addr = a; req_wdata = d;
      PSLVERR = serr; PREADY = 1'b0;
      #1;
      for (int k = 0; k < 8 && req_ready == 2'b00; k++) cyc();
      o_g = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -1;
      cyc();
      req_valid = hold; req_addr = 16'($urandom); req_wdata = {$urandom, $urandom};
      o_lat = 1; o_psel = 0; o_pen = 0; acc = 0; o_stable = 1'b1; o_extra = 1'b0;
      o_pa = '0; o_pw = '0; o_pwr = 1'b0;
      while (rsp_valid == 2'b00 && o_lat < 40) begin
         if (PSEL && o_psel == 0) o_psel = o_lat;
         if (PENABLE && o_pen == 0) o_pen = o_lat;
         if (req_ready != 2'b00) o_extra = 1'b1;
         if (PSEL && PENABLE) begin
            if (acc == 0) begin o_pa = PADDR; o_pw = PWDATA; o_pwr = PWRITE; end
            else if (PADDR !== o_pa || PWDATA !== o_pw || PWRITE !== o_pwr) o_stable = 1'b0;
            acc++;
            PREADY = acc > waits;
         end else if (acc > 0) o_stable = 1'b0;
         cyc();
         o_lat++;
      end
      o_rv = rsp_valid; o_rd = rsp_rdata; o_er = rsp_err;
      req_valid = 2'b00; PREADY = 1'b0; PSLVERR = 1'b0;
      cyc();
      o_rvn = rsp_valid;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      PREADY = 1'b0; PSLVERR = 1'b0;
      repeat (3) cyc();
      n_chk++; if (PSEL !== 1'b0) $display("FAIL rst_psel got %0b exp 0", PSEL); else n_pass++;
      n_chk++; if (PENABLE !== 1'b0) $display("FAIL rst_penable got %0b exp 0", PENABLE); else n_pass++;
      n_chk++; if (PWRITE !== 1'b0) $display("FAIL rst_pwrite got %0b exp 0", PWRITE); else n_pass++;
      n_chk++; if (PADDR !== 8'h0) $display("FAIL rst_paddr got %h exp 0", PADDR); else n_pass++;
      n_chk++; if (PWDATA !== 32'h0) $display("FAIL rst_pwdata got %h exp 0", PWDATA); else n_pass++;
      n_chk++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); else n_pass++;
      n_chk++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); else n_pass++;
      n_chk++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %0b exp 0", rsp_err); else n_pass++;
      PRESETn = 1'b1; ptr = 0;
      #1;
      n_chk++; if (req_ready !== 2'b00) $display("FAIL rst_ready got %b exp 00", req_ready); else n_pass++;
      cyc();
   endtask

   task automatic test_single_write();
      int e;
      e = pick(2'b01);
      issue(2'b01, 2'b01, {8'h00, 8'h04}, {32'h0, 32'hDEADBEEF}, 0, 1'b0, 2'b00);
      ptr = (e + 1) % 2; ref_mem[4] = 32'hDEADBEEF;
      n_chk++; if (o_g !== e) $display("FAIL sw_grant got %0d exp %0d", o_g, e); else n_pass++;
      n_chk++; if (o_psel !== 1) $display("FAIL sw_psel_cycle got %0d exp 1", o_psel); else n_pass++;
      n_chk++; if (o_pen !== 2) $display("FAIL sw_penable_cycle got %0d exp 2", o_pen); else n_pass++;
      n_chk++; if (o_lat !== 3) $display("FAIL sw_latency got %0d exp 3", o_lat); else n_pass++;
      n_chk++; if (o_rv !== 2'b01) $display("FAIL sw_rsp_valid got %b exp 01", o_rv); else n_pass++;
      n_chk++; if (o_er !== 1'b0) $display("FAIL sw_err got %0b exp 0", o_er); else n_pass++;
      n_chk++; if (o_rvn !== 2'b00) $display("FAIL sw_pulse got %b exp 00", o_rvn); else n_pass++;
      n_chk++; if (o_pa !== 8'h04 || o_pwr !== 1'b1 || o_pw !== 32'hDEADBEEF)
         $display("FAIL sw_bus got %h/%0b/%h exp 04/1/deadbeef", o_pa, o_pwr, o_pw); else n_pass++;
      e = pick(2'b01);
      issue(2'b01, 2'b00, {8'h00, 8'h04}, 64'h0, 0, 1'b0, 2'b00);
      ptr = (e + 1) % 2;
      n_chk++; if (o_g !== e) $display("FAIL rd_grant got %0d exp %0d", o_g, e); else n_pass++;
      n_chk++; if (o_rd !== 32'hDEADBEEF) $display("FAIL rd_data got %h exp deadbeef", o_rd); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int e;
      req_write = 2'b11; req_addr = {8'h08, 8'h00}; req_wdata = {32'h22222222, 32'h11111111};
      req_valid = 2'b11; PREADY = 1'b1; PSLVERR = 1'b0;
      #1;
      for (int n = 0; n < 6; n++) begin
         e = pick(2'b11);
         n_chk++; if (req_ready !== 2'(1 << e)) $display("FAIL b2b_grant%0d got %b exp %b", n, req_ready, 2'(1 << e)); else n_pass++;
         ptr = (e + 1) % 2;
         cyc();
         for (int k = 0; k < 10 && rsp_valid == 2'b00; k++) cyc();
         n_chk++; if (rsp_valid !== 2'(1 << e)) $display("FAIL b2b_rsp%0d got %b exp %b", n, rsp_valid, 2'(1 << e)); else n_pass++;
      end
      req_valid = 2'b00; PREADY = 1'b0;
      cyc();
      ref_mem[0] = 32'h11111111; ref_mem[8] = 32'h22222222;
      e = pick(2'b10);
      issue(2'b10, 2'b00, {8'h00, 8'h00}, 64'h0, 0, 1'b0, 2'b00);
      ptr = (e + 1) % 2;
      n_chk++; if (o_rd !== 32'h11111111) $display("FAIL b2b_rd0 got %h exp 11111111", o_rd); else n_pass++;
      e = pick(2'b01);
      issue(2'b01, 2'b00, {8'h00, 8'h08}, 64'h0, 0, 1'b0, 2'b00);
      ptr = (e + 1) % 2;
      n_chk++; if (o_rd !== 32'h22222222) $display("FAIL b2b_rd8 got %h exp 22222222", o_rd); else n_pass++;
   endtask

   task automatic test_wait_states();
      int e;
      e = pick(2'b10);
      issue(2'b10, 2'b00, {8'h08, 8'h00}, 64'h0, 5, 1'b0, 2'b01);
      ptr = (e + 1) % 2;
      n_chk++; if (o_g !== e) $display("FAIL ws_grant got %0d exp %0d", o_g, e); else n_pass++;
      n_chk++; if (o_lat !== 8) $display("FAIL ws_latency got %0d exp 8", o_lat); else n_pass++;
      n_chk++; if (o_stable !== 1'b1) $display("FAIL ws_stable got %0b exp 1", o_stable); else n_pass++;
      n_chk++; if (o_extra !== 1'b0) $display("FAIL ws_extra_grant got %0b exp 0", o_extra); else n_pass++;
      n_chk++; if (o_rv !== 2'b10) $display("FAIL ws_rsp_valid got %b exp 10", o_rv); else n_pass++;
      n_chk++; if (o_rd !== ref_mem[8]) $display("FAIL ws_rdata got %h exp %h", o_rd, ref_mem[8]); else n_pass++;
   endtask

   task automatic test_slverr();
      int e;
      e = pick(2'b01);
      issue(2'b01, 2'b00, {8'h00, 8'h0C}, 64'h0, 0, 1'b1, 2'b00);
      ptr = (e + 1) % 2;
      n_chk++; if (o_er !== 1'b1) $display("FAIL err_flag got %0b exp 1", o_er); else n_pass++;
      n_chk++; if (o_rv !== 2'b01) $display("FAIL err_rsp_valid got %b exp 01", o_rv); else n_pass++;
      n_chk++; if (o_rvn !== 2'b00) $display("FAIL err_pulse got %b exp 00", o_rvn); else n_pass++;
      e = pick(2'b01);
      issue(2'b01, 2'b00, {8'h00, 8'h0C}, 64'h0, 0, 1'b0, 2'b00);
      ptr = (e + 1) % 2;
      n_chk++; if (o_er !== 1'b0) $display("FAIL err_clear got %0b exp 0", o_er); else n_pass++;
      n_chk++; if (o_rd !== ref_mem[12]) $display("FAIL err_next_rd got %h exp %h", o_rd, ref_mem[12]); else n_pass++;
   endtask

   task automatic test_random();
      logic [1:0]  m, w;
      logic [7:0]  a0, a1, ea;
      logic [31:0] d0, d1, ed;
      logic        se;
      int          wt, e;
      for (int n = 0; n < 24; n++) begin
         m = 2'($urandom_range(1, 3)); w = 2'($urandom);
         a0 = 8'($urandom_range(0, 15) * 4); a1 = 8'($urandom_range(0, 15) * 4);
         d0 = $urandom; d1 = $urandom;
         wt = $urandom_range(0, 3); se = ($urandom_range(0, 3) == 0);
         e = pick(m);
         issue(m, w, {a1, a0}, {d1, d0}, wt, se, 2'b00);
         ea = e[0] ? a1 : a0;
         ed = w[e[0]] ? 32'h0 : ref_mem[ea];
         n_chk++; if (o_g !== e) $display("FAIL rnd%0d_grant got %0d exp %0d", n, o_g, e); else n_pass++;
         n_chk++; if (o_rv !== 2'(1 << e)) $display("FAIL rnd%0d_rsp_valid got %b exp %b", n, o_rv, 2'(1 << e)); else n_pass++;
         n_chk++; if (o_pa !== ea) $display("FAIL rnd%0d_paddr got %h exp %h", n, o_pa, ea); else n_pass++;
         n_chk++; if (o_rd !== ed) $display("FAIL rnd%0d_rdata got %h exp %h", n, o_rd, ed); else n_pass++;
         n_chk++; if (o_er !== se) $display("FAIL rnd%0d_err got %0b exp %0b", n, o_er, se); else n_pass++;
         n_chk++; if (o_lat !== 3 + wt) $display("FAIL rnd%0d_latency got %0d exp %0d", n, o_lat, 3 + wt); else n_pass++;
         ptr = (e + 1) % 2;
         if (w[e[0]] && !se) ref_mem[ea] = e[0] ? d1 : d0;
      end
   endtask

   task automatic test_reset_mid();
      req_valid = 2'b01; req_write = 2'b01; req_addr = {8'h08, 8'h10}; req_wdata = {32'h0, 32'hCAFEF00D};
      PREADY = 1'b0; PSLVERR = 1'b0;
      #1;
      for (int k = 0; k < 8 && req_ready == 2'b00; k++) cyc();
      cyc();
      req_valid = 2'b00;
      cyc();
      n_chk++; if (PENABLE !== 1'b1) $display("FAIL rm_access got %0b exp 1", PENABLE); else n_pass++;
      PRESETn = 1'b0; req_valid = 2'b10;
      cyc();
      n_chk++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) $display("FAIL rm_bus_idle got %0b%0b exp 00", PSEL, PENABLE); else n_pass++;
      n_chk++; if (rsp_valid !== 2'b00) $display("FAIL rm_no_rsp got %b exp 00", rsp_valid); else n_pass++;
      PRESETn = 1'b1; PREADY = 1'b1; ptr = 0;
      #1;
      n_chk++; if (req_ready !== 2'(1 << pick(2'b10))) $display("FAIL rm_grant got %b exp 10", req_ready); else n_pass++;
      ptr = (pick(2'b10) + 1) % 2;
      cyc();
      req_valid = 2'b00;
      for (int k = 0; k < 10 && rsp_valid == 2'b00; k++) cyc();
      n_chk++; if (rsp_valid !== 2'b10) $display("FAIL rm_rsp got %b exp 10", rsp_valid); else n_pass++;
      n_chk++; if (rsp_rdata !== ref_mem[8]) $display("FAIL rm_rdata got %h exp %h", rsp_rdata, ref_mem[8]); else n_pass++;
      PREADY = 1'b0;
      cyc();
   endtask

`ifdef APB_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int e;
      e = pick(2'b01);
      issue(2'b01, 2'b00, {8'h00, 8'h04}, 64'h0, 1000, 1'b0, 2'b00);
      ptr = (e + 1) % 2;
      n_chk++; if (o_lat !== 18) $display("FAIL to_latency got %0d exp 18", o_lat); else n_pass++;
      n_chk++; if (o_er !== 1'b1) $display("FAIL to_err got %0b exp 1", o_er); else n_pass++;
      n_chk++; if (o_rd !== 32'h0) $display("FAIL to_rdata got %h exp 0", o_rd); else n_pass++;
      n_chk++; if (o_rv !== 2'b01) $display("FAIL to_rsp_valid got %b exp 01", o_rv); else n_pass++;
      n_chk++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) $display("FAIL to_idle got %0b%0b exp 00", PSEL, PENABLE); else n_pass++;
   endtask
`endif

   initial begin
      n_chk = 0; n_pass = 0; ptr = 0;
      for (int i = 0; i < 256; i++) begin smem[i] = '0; ref_mem[i] = '0; end
      test_reset();
      test_single_write();
      test_back_to_back();
      test_wait_states();
      test_slverr();
      test_random();
      test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
